lfsr_seq_checker: RTL and testbench
===================================

Name: lfsr_seq_checker

Overview:
Receive-side companion to the 20-bit LFSR counter (polynomial X^20 + X^13 + X^9 + X^5 + 1, right-shift form). It samples the generator's state stream and synchronises to it. It predicts each next state, flags and counts divergences, and reports lock status. It sits downstream of the generator, or at the far end of a link carrying its states, and serves as a built-in sequence-integrity monitor.

Parameters:
LOCK_MATCHES, 4, consecutive correct predictions required to enter LOCKED (range 1..15)
LOSS_ERRORS, 3, consecutive mispredictions in LOCKED that drop back to HUNT (range 1..15)
ERR_CNT_W, 16, width of the saturating error counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low; all flops go to reset values while rst=0
in_valid  in  1  in_state is a sample to check this cycle
in_state  in  20  observed LFSR state
err_clr  in  1  synchronous clear of err_count (takes priority over increment)
locked  out  1  checker is in LOCKED
err_pulse  out  1  one-cycle pulse, registered, for each mismatch detected in LOCKED
err_count  out  ERR_CNT_W  saturating count of mismatches seen in LOCKED
expected  out  20  current predicted next state

Behaviour:
- Step function: step(s) = {d0, s[19:1]}, where d0 = s[15]^s[11]^s[7]^s[0].
- step(0) = 0, so all-zero is the lock-up state and is never a valid sample.
- Reset values: locked=0, err_pulse=0, err_count=0, expected=0, FSM=HUNT, match_run=0, miss_run=0.
- All outputs are registered. Response to a sample appears on the clock edge that captures it.
- in_valid=0: no state changes; err_pulse=0.
- FSM states: HUNT, VERIFY, LOCKED.
- HUNT, on in_valid:
  - in_state==0: ignored; remain in HUNT.
  - Otherwise: expected<=step(in_state), match_run<=0, go to VERIFY.
- VERIFY, on in_valid:
  - in_state==expected: match_run++, expected<=step(in_state). When match_run+1==LOCK_MATCHES, go to LOCKED, locked<=1, miss_run<=0.
  - Mismatch: reseed with expected<=step(in_state) and match_run<=0; stay in VERIFY.
  - Mismatch in_state==0: go to HUNT.
  - Mismatches in VERIFY are never counted as errors.
- LOCKED, on in_valid (flywheel mode):
  - expected<=step(expected) regardless of the comparison result; no reseed from the input.
  - Match: miss_run<=0.
  - Mismatch (including in_state==0): err_pulse<=1, err_count increments, saturating at all-ones, miss_run++.
  - When miss_run+1==LOSS_ERRORS: go to HUNT, locked<=0, match_run<=0. err_pulse and the count still apply to this final mismatch.
- err_clr=1 in the same cycle as a mismatch: err_count<=0 (clear wins); err_pulse still asserts.
- Reset asserted mid-operation: immediate return to reset values. No lock is retained after reset.
- Latency: sample to err_pulse/locked is 1 clock edge.

Decomposition:
- Shared package lfsr_pkg:
  - LFSR_W=20
  - tap constants (bit indices 15, 11, 7, 0)
  - FSM state typedef {HUNT, VERIFY, LOCKED}
  - step() function, so the generator and checker share one definition
- One natural sub-module: lfsr_next, a combinational 20-bit next-state step instantiated twice (from in_state and from expected).
- Counters, FSM and compare logic stay in lfsr_seq_checker.

Test Plan:
1. Lock acquisition: reset, then feed 0x00001, 0x80000, 0x40000, 0x20000, 0x10000 on consecutive valid cycles -> locked=1 after the edge sampling 0x10000; expected=0x08000; err_count=0.
2. Single error in LOCKED: from test 1, feed 0x12345, then 0x84000 -> err_pulse high for exactly one cycle after 0x12345; err_count=1; locked stays 1; no pulse for 0x84000; expected=step(0x84000).
3. Loss of lock: from locked, feed three consecutive wrong values (0xABCDE, 0x00000, 0x11111) -> err_count=3, locked=0 after the third; FSM=HUNT; a fourth wrong sample produces no pulse.
4. Zero and reseed handling: in HUNT feed 0x00000 -> stays in HUNT, expected=0. Then feed 0x00001, 0x55555 -> VERIFY reseeds, expected=step(0x55555), no err_pulse. Gaps in in_valid within a lock sequence leave state unchanged.
5. Counter saturation and clear (ERR_CNT_W=2): produce 5 mismatches while relocking as needed -> err_count holds 3. Assert err_clr together with a mismatch -> err_count=0 and err_pulse=1.
6. Async reset mid-lock: drop rst between clock edges while locked -> locked, err_count, err_pulse and expected go to 0 without a clock edge. After release, the sequence from test 1 relocks in 5 samples.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 20-bit LFSR (x^20+x^13+x^9+x^5+1, right-shift form).
package lfsr_pkg;
  localparam int LFSR_W = 20;
  localparam int TAP_A  = 15;
  localparam int TAP_B  = 11;
  localparam int TAP_C  = 7;
  localparam int TAP_D  = 0;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // One LFSR advance; generator and checker must agree on this exactly.
  function automatic logic [LFSR_W-1:0] step(input logic [LFSR_W-1:0] s);
    return {s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D], s[LFSR_W-1:1]};
  endfunction
endpackage

// File: rtl/lfsr_next.sv
// Combinational single-step of the LFSR state.
module lfsr_next
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt
);
  // Pure feedback step, no state.
  assign nxt = step(cur);
endmodule

// File: rtl/lfsr_seq_checker.sv
// Receive-side LFSR sequence checker: hunts for a seed, verifies a run of
// correct predictions, then flywheels and counts divergences while locked.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_MATCHES = 4,
  parameter int LOSS_ERRORS  = 3,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [LFSR_W-1:0]    in_state,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [LFSR_W-1:0]    expected
);
  localparam logic [3:0] LOCK_N = 4'(LOCK_MATCHES);
  localparam logic [3:0] LOSS_N = 4'(LOSS_ERRORS);

  chk_state_e             state_q, state_d;
  logic [3:0]             match_q, match_d;
  logic [3:0]             miss_q, miss_d;
  logic [LFSR_W-1:0]      exp_d;
  logic [ERR_CNT_W-1:0]   cnt_d;
  logic                   pulse_d;
  logic                   bump;
  logic                   hit;
  logic                   zero;
  logic [LFSR_W-1:0]      step_in;
  logic [LFSR_W-1:0]      step_exp;

  // Reseed path (from the sample) and flywheel path (from the prediction).
  lfsr_next u_next_in  (.cur(in_state), .nxt(step_in));
  lfsr_next u_next_exp (.cur(expected), .nxt(step_exp));

  assign hit  = (in_state == expected);
  assign zero = (in_state == '0);

  // Next-state, prediction, run counters and error decision.
  always_comb begin
    state_d = state_q;
    exp_d   = expected;
    match_d = match_q;
    miss_d  = miss_q;
    pulse_d = 1'b0;
    bump    = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          // All-zero is the lock-up state, never a usable seed.
          if (!zero) begin
            exp_d   = step_in;
            match_d = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            match_d = match_q + 4'd1;
            exp_d   = step_in;
            if (match_q + 4'd1 == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (zero) begin
            state_d = HUNT;
          end else begin
            exp_d   = step_in;
            match_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the input never reseeds the prediction once locked.
          exp_d = step_exp;
          if (hit) begin
            miss_d = '0;
          end else begin
            pulse_d = 1'b1;
            bump    = 1'b1;
            miss_d  = miss_q + 4'd1;
            if (miss_q + 4'd1 == LOSS_N) begin
              state_d = HUNT;
              match_d = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    // Clear wins over a same-cycle increment; saturate at all-ones.
    if (err_clr)                      cnt_d = '0;
    else if (bump && err_count != '1) cnt_d = err_count + ERR_CNT_W'(1);
    else                              cnt_d = err_count;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= HUNT;
      match_q   <= '0;
      miss_q    <= '0;
      expected  <= '0;
      err_count <= '0;
      err_pulse <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      expected  <= exp_d;
      err_count <= cnt_d;
      err_pulse <= pulse_d;
      locked    <= (state_d == LOCKED);
    end
  end
endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench with a reference model feeding a scoreboard queue.
module tb_lfsr_seq_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic [19:0] in_state = '0;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [19:0] expected;
  logic        locked2, err_pulse2;
  logic [1:0]  err_count2;
  logic [19:0] expected2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        lk;
    logic        pl;
    logic [15:0] c16;
    logic [1:0]  c2;
    logic [19:0] ex;
  } exp_t;
  exp_t sb[$];

  int          m_st;
  logic [19:0] m_exp;
  int          m_match, m_miss, m_c16, m_c2;

  lfsr_seq_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_state(in_state),
    .err_clr(err_clr), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .expected(expected)
  );

  lfsr_seq_checker #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_state(in_state),
    .err_clr(err_clr), .locked(locked2), .err_pulse(err_pulse2),
    .err_count(err_count2), .expected(expected2)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] ref_step(input logic [19:0] s);
    logic fb;
    fb = ^(s & 20'h08881);
    return (s >> 1) | ({19'd0, fb} << 19);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_exp = '0; m_match = 0; m_miss = 0; m_c16 = 0; m_c2 = 0;
  endtask

  // Drive one cycle, predict the result, then compare after the edge.
  task automatic drive(input logic v, input logic [19:0] s, input logic clr);
    exp_t        e;
    logic [19:0] old;
    in_valid = v; in_state = s; err_clr = clr;
    e.pl = 1'b0;
    old  = m_exp;
    if (v) begin
      case (m_st)
        0: if (s != 0) begin m_exp = ref_step(s); m_match = 0; m_st = 1; end
        1: begin
          if (s == old) begin
            m_match++; m_exp = ref_step(s);
            if (m_match == 4) begin m_st = 2; m_miss = 0; end
          end else if (s == 0) m_st = 0;
          else begin m_exp = ref_step(s); m_match = 0; end
        end
        default: begin
          m_exp = ref_step(old);
          if (s == old) m_miss = 0;
          else begin
            e.pl = 1'b1;
            if (m_c16 < 65535) m_c16++;
            if (m_c2 < 3) m_c2++;
            m_miss++;
            if (m_miss == 3) begin m_st = 0; m_match = 0; end
          end
        end
      endcase
    end
    if (clr) begin m_c16 = 0; m_c2 = 0; end
    e.lk  = (m_st == 2);
    e.c16 = m_c16[15:0];
    e.c2  = m_c2[1:0];
    e.ex  = m_exp;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("locked",     {31'd0, locked},     {31'd0, e.lk});
      check("err_pulse",  {31'd0, err_pulse},  {31'd0, e.pl});
      check("err_count",  {16'd0, err_count},  {16'd0, e.c16});
      check("expected",   {12'd0, expected},   {12'd0, e.ex});
      check("err_count2", {30'd0, err_count2}, {30'd0, e.c2});
      check("locked2",    {31'd0, locked2},    {31'd0, e.lk});
    end
    in_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic lock_seq();
    drive(1, 20'h00001, 0);
    drive(1, 20'h80000, 0);
    drive(1, 20'h40000, 0);
    drive(1, 20'h20000, 0);
    drive(1, 20'h10000, 0);
  endtask

  initial begin
    model_reset();
    // Reset state
    #2;
    check("rst_locked",   {31'd0, locked},    32'd0);
    check("rst_pulse",    {31'd0, err_pulse}, 32'd0);
    check("rst_count",    {16'd0, err_count}, 32'd0);
    check("rst_expected", {12'd0, expected},  32'd0);
    #10 rst = 1'b1;

    // 1: lock acquisition
    lock_seq();
    check("t1_locked",   {31'd0, locked},   32'd1);
    check("t1_expected", {12'd0, expected}, 32'h08000);

    // 2: single error, flywheel continues
    drive(1, 20'h12345, 0);
    check("t2_pulse", {31'd0, err_pulse}, 32'd1);
    drive(1, 20'h84000, 0);
    check("t2_nopulse",  {31'd0, err_pulse}, 32'd0);
    check("t2_count",    {16'd0, err_count}, 32'd1);
    check("t2_expected", {12'd0, expected},  32'h42000);

    // 3: loss of lock
    drive(1, 20'hABCDE, 0);
    drive(1, 20'h00000, 0);
    drive(1, 20'h11111, 0);
    check("t3_count",  {16'd0, err_count}, 32'd4);
    check("t3_locked", {31'd0, locked},    32'd0);
    drive(1, 20'h00000, 0);
    check("t3_nopulse", {31'd0, err_pulse}, 32'd0);

    // 4: zero handling and reseed, with gaps
    rst = 1'b0; #2; rst = 1'b1;
    model_reset();
    drive(1, 20'h00000, 0);
    check("t4_zero_exp", {12'd0, expected}, 32'd0);
    drive(1, 20'h00001, 0);
    drive(1, 20'h55555, 0);
    check("t4_reseed", {12'd0, expected},  32'hAAAAA);
    check("t4_pulse",  {31'd0, err_pulse}, 32'd0);
    drive(0, 20'h12345, 0);
    check("t4_gap", {12'd0, expected}, 32'hAAAAA);
    for (int i = 0; i < 4; i++) begin
      drive(1, m_exp, 0);
      drive(0, 20'h0, 0);
    end
    check("t4_locked", {31'd0, locked}, 32'd1);

    // 5: saturation (2-bit instance) and clear priority
    for (int i = 0; i < 3; i++) drive(1, m_exp ^ 20'h1, 0);
    lock_seq();
    drive(1, m_exp ^ 20'h1, 0);
    drive(1, m_exp ^ 20'h1, 0);
    check("t5_count16", {16'd0, err_count}, 32'd5);
    check("t5_sat",     {30'd0, err_count2}, 32'd3);
    drive(1, m_exp, 0);
    drive(1, m_exp ^ 20'h1, 1);
    check("t5_clr",   {16'd0, err_count},  32'd0);
    check("t5_clr2",  {30'd0, err_count2}, 32'd0);
    check("t5_pulse", {31'd0, err_pulse},  32'd1);

    // 6: async reset while locked
    drive(1, m_exp ^ 20'h1, 0);
    #2 rst = 1'b0;
    #1;
    check("t6_locked",   {31'd0, locked},    32'd0);
    check("t6_count",    {16'd0, err_count}, 32'd0);
    check("t6_pulse",    {31'd0, err_pulse}, 32'd0);
    check("t6_expected", {12'd0, expected},  32'd0);
    model_reset();
    sb.delete();
    #3 rst = 1'b1;
    lock_seq();
    check("t6_relock",   {31'd0, locked},   32'd1);
    check("t6_expected2", {12'd0, expected}, 32'h08000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
